// File: rtl/lfsr_checker_if.sv
// Word stream into the LFSR checker and its status/counter outputs.
// The source side (pattern link / bench) uses master; the checker uses slave.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [11:0]      in_word;
  logic             clear_counts;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] error_count;
  logic [1:0]       state;

  modport master (
    output in_valid, in_word, clear_counts,
    input  locked, error, match_count, error_count, state
  );

  modport slave (
    input  in_valid, in_word, clear_counts,
    output locked, error, match_count, error_count, state
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 12-bit LFSR pattern: hunts for sync, verifies,
// then flywheels the prediction while locked and counts matches/mismatches.
module lfsr_checker #(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_MISSES = 3,
  parameter int CNT_W         = 16
) (
  input logic          clock,
  input logic          reset,
  lfsr_checker_if.slave bus
);
  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_MISSES + 1);
  localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] UNLOCK_TGT = MW'(UNLOCK_MISSES);

  function automatic logic [11:0] nxt(input logic [11:0] x);
    return (x == 12'd0) ? 12'hFFF : {x[10:0], x[8] ^ x[3]};
  endfunction

  state_t           state_q, state_d;
  logic [11:0]      expected_q, expected_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [MW-1:0]    miss_q, miss_d, miss_inc;
  logic             error_q, error_d;
  logic [CNT_W-1:0] mcount_q, mcount_d;
  logic [CNT_W-1:0] ecount_q, ecount_d;
  logic             match_inc, err_inc;

  assign good_inc = good_q + 1'b1;
  assign miss_inc = miss_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    miss_d     = miss_q;
    error_d    = 1'b0;
    match_inc  = 1'b0;
    err_inc    = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          expected_d = nxt(bus.in_word);
          good_d     = '0;
          state_d    = VERIFY;
        end
        VERIFY: begin
          if (bus.in_word == expected_q) begin
            good_d     = good_inc;
            expected_d = nxt(expected_q);
            if (good_inc == LOCK_TGT) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            expected_d = nxt(bus.in_word);
            good_d     = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction never reseeds from the input while locked.
          expected_d = nxt(expected_q);
          if (bus.in_word == expected_q) begin
            match_inc = 1'b1;
            miss_d    = '0;
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_inc;
            if (miss_inc == UNLOCK_TGT) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    mcount_d = mcount_q;
    ecount_d = ecount_q;
    if (bus.clear_counts) begin
      mcount_d = '0;
      ecount_d = '0;
    end else begin
      if (match_inc && (mcount_q != '1)) mcount_d = mcount_q + 1'b1;
      if (err_inc && (ecount_q != '1))   ecount_d = ecount_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= HUNT;
      expected_q <= 12'hFFF;
      good_q     <= '0;
      miss_q     <= '0;
      error_q    <= 1'b0;
      mcount_q   <= '0;
      ecount_q   <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      error_q    <= error_d;
      mcount_q   <= mcount_d;
      ecount_q   <= ecount_d;
    end
  end

  assign bus.locked      = (state_q == LOCKED);
  assign bus.error       = error_q;
  assign bus.match_count = mcount_q;
  assign bus.error_count = ecount_q;
  assign bus.state       = state_q;
endmodule
